// File: rtl/profile_gen_mc_if.sv
// Host parameter bus for profile_gen_mc: register address, write strobes, readback.
interface profile_gen_mc_if;
    logic [7:0]  param_addr;
    logic [31:0] param_in;
    logic        param_write_lo;
    logic        param_write_hi;
    logic        param_read;
    logic        param_read_hi;
    logic [31:0] param_out;

    modport master (
        output param_addr, param_in, param_write_lo, param_write_hi, param_read, param_read_hi,
        input  param_out
    );

    modport slave (
        input  param_addr, param_in, param_write_lo, param_write_hi, param_read, param_read_hi,
        output param_out
    );
endinterface

// File: rtl/profile_gen_mc.sv
// Multi-channel jerk-limited profile generator: one shared adder engine sweeps all busy
// channels per acc_step, emitting step/dir and done pulses.
module profile_gen_mc #(
    parameter int unsigned N_CH     = 8,
    parameter int unsigned W        = 64,
    parameter int unsigned STEP_BIT = 32
) (
    input  logic            clk,
    input  logic            rst,
    profile_gen_mc_if.slave bus,
    input  logic            acc_step,
    input  logic [N_CH-1:0] abort,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] done,
    output logic [N_CH-1:0] step,
    output logic [N_CH-1:0] dir,
    output logic            overrun
);

    typedef enum logic [0:0] {StIdle, StSweep} state_e;

    state_e          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [W-1:0]    x_q [N_CH];
    logic [W-1:0]    x_d [N_CH];
    logic [W-1:0]    v_q [N_CH];
    logic [W-1:0]    v_d [N_CH];
    logic [W-1:0]    a_q [N_CH];
    logic [W-1:0]    a_d [N_CH];
    logic [W-1:0]    j_q [N_CH];
    logic [W-1:0]    j_d [N_CH];
    logic [W-1:0]    n_q [N_CH];
    logic [W-1:0]    n_d [N_CH];
    logic [N_CH-1:0] busy_q, busy_d, done_q, done_d, step_q, step_d, dir_q, dir_d;
    logic            overrun_q, overrun_d;
    logic [31:0]     out_q, out_d;

    logic [2:0] sel_ch;
    logic [4:0] sel_reg;
    logic       ch_ok;

    assign sel_ch  = bus.param_addr[7:5];
    assign sel_reg = bus.param_addr[4:0];
    assign ch_ok   = 32'(sel_ch) < N_CH;

    function automatic logic [W-1:0] merge(logic [W-1:0] old, logic lo, logic hi,
                                           logic [31:0] data);
        logic [W-1:0] r;
        r = old;
        if (lo) r[31:0] = data;
        if (hi) r[W-1:32] = data[W-33:0];
        return r;
    endfunction

    always_comb begin
        logic         hit, ctrl_wr, kill, upd, wr_lo, wr_hi;
        logic [W-1:0] x_nxt, n_nxt;
        logic [63:0]  rd_val;

        state_d   = state_q;
        ptr_d     = ptr_q;
        overrun_d = 1'b0;
        busy_d    = busy_q;
        done_d    = '0;
        step_d    = '0;
        dir_d     = dir_q;
        x_d       = x_q;
        v_d       = v_q;
        a_d       = a_q;
        j_d       = j_q;
        n_d       = n_q;
        out_d     = out_q;
        hit       = 1'b0;
        ctrl_wr   = 1'b0;
        kill      = 1'b0;
        upd       = 1'b0;
        x_nxt     = '0;
        n_nxt     = '0;
        rd_val    = '0;
        wr_lo     = bus.param_write_lo;
        wr_hi     = bus.param_write_hi;

        unique case (state_q)
            StIdle: begin
                if (acc_step) begin
                    state_d = StSweep;
                    ptr_d   = '0;
                end
            end
            StSweep: begin
                // A second acc_step during a sweep is flagged and otherwise dropped.
                if (acc_step) overrun_d = 1'b1;
                if (ptr_q == 3'(N_CH - 1)) state_d = StIdle;
                else ptr_d = ptr_q + 3'd1;
            end
            default: state_d = StIdle;
        endcase

        for (int c = 0; c < N_CH; c++) begin
            hit     = ch_ok && (sel_ch == 3'(c));
            ctrl_wr = hit && wr_lo && (sel_reg == 5'd5);
            kill    = abort[c] | (ctrl_wr & bus.param_in[1]);
            upd     = (state_q == StSweep) && (ptr_q == 3'(c)) && busy_q[c];
            if (kill) begin
                v_d[c]    = '0;
                a_d[c]    = '0;
                j_d[c]    = '0;
                n_d[c]    = '0;
                busy_d[c] = 1'b0;
            end else if (upd) begin
                x_nxt     = x_q[c] + v_q[c];
                n_nxt     = n_q[c] - 1'b1;
                x_d[c]    = x_nxt;
                v_d[c]    = v_q[c] + a_q[c];
                a_d[c]    = a_q[c] + j_q[c];
                n_d[c]    = n_nxt;
                step_d[c] = x_nxt[STEP_BIT] ^ x_q[c][STEP_BIT];
                dir_d[c]  = v_q[c][W-1];
                if (n_nxt == '0) begin
                    busy_d[c] = 1'b0;
                    done_d[c] = 1'b1;
                end
            end else begin
                if (hit && !busy_q[c]) begin
                    case (sel_reg)
                        5'd0:    x_d[c] = merge(x_q[c], wr_lo, wr_hi, bus.param_in);
                        5'd1:    v_d[c] = merge(v_q[c], wr_lo, wr_hi, bus.param_in);
                        5'd2:    a_d[c] = merge(a_q[c], wr_lo, wr_hi, bus.param_in);
                        5'd3:    j_d[c] = merge(j_q[c], wr_lo, wr_hi, bus.param_in);
                        5'd4:    n_d[c] = merge(n_q[c], wr_lo, wr_hi, bus.param_in);
                        default: ;
                    endcase
                end
                if (ctrl_wr && bus.param_in[0]) begin
                    if (n_q[c] != '0) busy_d[c] = 1'b1;
                    else done_d[c] = 1'b1;
                end
            end
        end

        // Readback samples the current registers, so it sees pre-update values.
        if (bus.param_read) begin
            if (ch_ok) begin
                case (sel_reg)
                    5'd0:    rd_val = 64'(x_q[sel_ch]);
                    5'd1:    rd_val = 64'(v_q[sel_ch]);
                    5'd2:    rd_val = 64'(a_q[sel_ch]);
                    5'd3:    rd_val = 64'(j_q[sel_ch]);
                    5'd4:    rd_val = 64'(n_q[sel_ch]);
                    5'd5:    rd_val = {62'b0, busy_q[sel_ch], 1'b0};
                    default: rd_val = '0;
                endcase
            end
            out_d = bus.param_read_hi ? rd_val[63:32] : rd_val[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            busy_q    <= '0;
            done_q    <= '0;
            step_q    <= '0;
            dir_q     <= '0;
            overrun_q <= 1'b0;
            out_q     <= '0;
            for (int c = 0; c < N_CH; c++) begin
                x_q[c] <= '0;
                v_q[c] <= '0;
                a_q[c] <= '0;
                j_q[c] <= '0;
                n_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            overrun_q <= overrun_d;
            out_q     <= out_d;
            x_q       <= x_d;
            v_q       <= v_d;
            a_q       <= a_d;
            j_q       <= j_d;
            n_q       <= n_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign step          = step_q;
    assign dir           = dir_q;
    assign overrun       = overrun_q;
    assign bus.param_out = out_q;

endmodule

// File: tb/tb_profile_gen_mc.sv
// Scoreboard bench for profile_gen_mc: readback expectations are queued when a read is
// issued and compared when param_out becomes valid; pulse outputs are counted by a monitor.
module tb_profile_gen_mc;
    localparam int N_CH = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            acc_step = 1'b0;
    logic [N_CH-1:0] abort = '0;
    logic [N_CH-1:0] busy, done, step, dir;
    logic            overrun;

    always #5 clk = ~clk;

    profile_gen_mc_if bus();

    profile_gen_mc #(.N_CH(N_CH), .W(64), .STEP_BIT(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .acc_step (acc_step),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .step     (step),
        .dir      (dir),
        .overrun  (overrun)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   step_cnt[N_CH];
    int   done_cnt[N_CH];
    logic last_dir[N_CH];
    int   ovr_cnt;
    logic rd_v;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) rd_v <= 1'b0;
        else rd_v <= bus.param_read;
    end

    always @(negedge clk) begin
        if (rd_v) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check(e.tag, bus.param_out, e.val);
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            if (step[c]) begin
                step_cnt[c]++;
                last_dir[c] = dir[c];
            end
            if (done[c]) done_cnt[c]++;
        end
        if (overrun) ovr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        for (int c = 0; c < N_CH; c++) begin
            step_cnt[c] = 0;
            done_cnt[c] = 0;
            last_dir[c] = 1'b0;
        end
        ovr_cnt = 0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic lo,
                      input logic hi);
        bus.param_addr     = addr;
        bus.param_in       = data;
        bus.param_write_lo = lo;
        bus.param_write_hi = hi;
        tick();
        bus.param_write_lo = 1'b0;
        bus.param_write_hi = 1'b0;
    endtask

    task automatic wr64(input logic [7:0] addr, input logic [31:0] hi, input logic [31:0] lo);
        wr(addr, lo, 1'b1, 1'b0);
        wr(addr, hi, 1'b0, 1'b1);
    endtask

    task automatic rd(input logic [7:0] addr, input logic hi, input string tag,
                      input logic [31:0] exp);
        exp_t x;
        x.tag = tag;
        x.val = exp;
        sb.push_back(x);
        bus.param_addr    = addr;
        bus.param_read    = 1'b1;
        bus.param_read_hi = hi;
        tick();
        bus.param_read    = 1'b0;
        bus.param_read_hi = 1'b0;
    endtask

    task automatic rd64(input logic [7:0] addr, input string tag, input logic [63:0] exp);
        rd(addr, 1'b0, {tag, "_lo"}, exp[31:0]);
        rd(addr, 1'b1, {tag, "_hi"}, exp[63:32]);
    endtask

    task automatic acc();
        acc_step = 1'b1;
        tick();
        acc_step = 1'b0;
        repeat (N_CH + 2) tick();
    endtask

    int          t2_step[4] = '{0, 1, 1, 2};
    logic [31:0] t3_x[3] = '{0, 0, 1};
    logic [31:0] t3_v[3] = '{0, 1, 3};
    logic [31:0] t3_a[3] = '{1, 2, 3};

    initial begin
        bus.param_addr     = '0;
        bus.param_in       = '0;
        bus.param_write_lo = 1'b0;
        bus.param_write_hi = 1'b0;
        bus.param_read     = 1'b0;
        bus.param_read_hi  = 1'b0;
        clear_cnt();
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // T1: reset asserted in the middle of a sweep
        wr64(8'h01, 32'h0, 32'h8000_0000);
        wr64(8'h04, 32'h0, 32'd4);
        wr(8'h05, 32'h1, 1'b1, 1'b0);
        acc_step = 1'b1;
        tick();
        acc_step = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_step", step, 0);
        check("rst_dir", dir, 0);
        check("rst_overrun", overrun, 0);
        check("rst_param_out", bus.param_out, 0);
        for (int c = 0; c < N_CH; c++) begin
            for (int r = 0; r < 6; r++) begin
                rd64(8'((c << 5) | r), $sformatf("rst_ch%0d_r%0d", c, r), 64'h0);
            end
        end
        clear_cnt();
        acc();
        check("rst_no_step", step_cnt[0], 0);

        // T2: constant velocity, steps on bit-32 transitions
        clear_cnt();
        wr64(8'h00, 32'h0, 32'h0);
        wr64(8'h01, 32'h0, 32'h8000_0000);
        wr64(8'h04, 32'h0, 32'd4);
        wr(8'h05, 32'h1, 1'b1, 1'b0);
        check("t2_busy_set", busy[0], 1);
        rd(8'h05, 1'b0, "t2_ctrl_rd", 32'h2);
        wr(8'h01, 32'h1234, 1'b1, 1'b0);
        rd(8'h01, 1'b0, "t2_wr_ignored", 32'h8000_0000);
        rd(8'h06, 1'b0, "t2_bad_reg", 32'h0);
        for (int u = 0; u < 4; u++) begin
            acc();
            check($sformatf("t2_step_u%0d", u + 1), step_cnt[0], t2_step[u]);
            check($sformatf("t2_done_u%0d", u + 1), done_cnt[0], (u == 3) ? 1 : 0);
        end
        check("t2_dir", last_dir[0], 0);
        check("t2_busy_end", busy[0], 0);
        rd64(8'h00, "t2_x", 64'h2_0000_0000);

        // T3: jerk integration
        clear_cnt();
        wr64(8'h60, 32'h0, 32'h0);
        wr64(8'h61, 32'h0, 32'h0);
        wr64(8'h62, 32'h0, 32'h0);
        wr64(8'h63, 32'h0, 32'h1);
        wr64(8'h64, 32'h0, 32'd3);
        wr(8'h65, 32'h1, 1'b1, 1'b0);
        for (int u = 0; u < 3; u++) begin
            acc();
            rd(8'h60, 1'b0, $sformatf("t3_x_u%0d", u + 1), t3_x[u]);
            rd(8'h61, 1'b0, $sformatf("t3_v_u%0d", u + 1), t3_v[u]);
            rd(8'h62, 1'b0, $sformatf("t3_a_u%0d", u + 1), t3_a[u]);
        end
        check("t3_busy_end", busy[3], 0);
        check("t3_done", done_cnt[3], 1);

        // T4: negative velocity; also a combined hi+lo write on an idle channel
        clear_cnt();
        wr(8'hA3, 32'h1234_5678, 1'b1, 1'b1);
        rd64(8'hA3, "t4_both_halves", 64'h1234_5678_1234_5678);
        wr64(8'hE0, 32'h0, 32'h0);
        wr64(8'hE1, 32'hFFFF_FFFF, 32'hFFFF_FED4);
        wr64(8'hE4, 32'h0, 32'd10);
        wr(8'hE5, 32'h1, 1'b1, 1'b0);
        for (int u = 0; u < 10; u++) begin
            acc();
            if (u == 0) begin
                check("t4_step_u1", step_cnt[7], 1);
                check("t4_dir_u1", last_dir[7], 1);
            end
        end
        check("t4_step_total", step_cnt[7], 1);
        check("t4_done", done_cnt[7], 1);
        check("t4_busy_end", busy[7], 0);
        rd64(8'hE0, "t4_x", 64'hFFFF_FFFF_FFFF_F448);

        // T5: hardware abort between sweeps
        clear_cnt();
        wr64(8'h20, 32'h0, 32'h0);
        wr64(8'h21, 32'h0, 32'd70);
        wr64(8'h24, 32'h0, 32'd5);
        wr(8'h25, 32'h1, 1'b1, 1'b0);
        acc();
        acc();
        acc_step = 1'b1;
        tick();
        acc_step = 1'b0;
        repeat (12) tick();
        abort[1] = 1'b1;
        tick();
        abort = '0;
        check("t5_busy", busy[1], 0);
        rd(8'h21, 1'b0, "t5_v", 32'h0);
        rd(8'h24, 1'b0, "t5_n", 32'h0);
        rd(8'h20, 1'b0, "t5_x", 32'd210);
        acc();
        acc();
        rd(8'h20, 1'b0, "t5_x_after", 32'd210);
        check("t5_no_done", done_cnt[1], 0);
        check("t5_no_step", step_cnt[1], 0);

        // T6: overrun and abort colliding with the sweep slot of ch2
        clear_cnt();
        wr64(8'h41, 32'h0, 32'd5);
        wr64(8'h44, 32'h0, 32'd10);
        wr(8'h45, 32'h1, 1'b1, 1'b0);
        wr64(8'h81, 32'h0, 32'd1);
        wr64(8'h84, 32'h0, 32'd10);
        wr(8'h85, 32'h1, 1'b1, 1'b0);
        acc_step = 1'b1;
        tick();
        acc_step = 1'b0;
        repeat (2) tick();
        acc_step = 1'b1;
        abort[2] = 1'b1;
        tick();
        acc_step = 1'b0;
        abort = '0;
        repeat (N_CH + 2) tick();
        check("t6_overrun", ovr_cnt, 1);
        rd(8'h80, 1'b0, "t6_ch4_x", 32'd1);
        rd(8'h40, 1'b0, "t6_ch2_x", 32'd0);
        rd(8'h41, 1'b0, "t6_ch2_v", 32'd0);
        check("t6_ch2_busy", busy[2], 0);
        check("t6_ch4_busy", busy[4], 1);

        // Start with N==0: done pulses, busy stays clear
        wr(8'hC5, 32'h1, 1'b1, 1'b0);
        check("n0_busy", busy[6], 0);
        tick();
        check("n0_done", done_cnt[6], 1);

        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
